// File: rtl/ym3438_bus_master.sv
// Host-side YM3438 CPU bus initiator: address write, data write, then optional
// busy-flag polling of the status register. Every output is registered.
module ym3438_bus_master #(
    parameter int unsigned SETUP_CYCLES  = 2,
    parameter int unsigned STROBE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 2,
    parameter int unsigned POLL_EN       = 1,
    parameter int unsigned POLL_LIMIT    = 255
) (
    input  logic       MCLK,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_bank,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       done,
    output logic       timeout,
    output logic [7:0] last_status,
    output logic       CS,
    output logic       WR,
    output logic       RD,
    output logic [1:0] ADDRESS,
    output logic [7:0] bus_data_o,
    output logic       bus_data_oe,
    input  logic [7:0] bus_data_i
);

    localparam int unsigned MAX_SW = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int unsigned MAX_C  = (MAX_SW > HOLD_CYCLES) ? MAX_SW : HOLD_CYCLES;
    localparam int unsigned CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] S_LD  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] W_LD  = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] H_LD  = CW'(HOLD_CYCLES - 1);
    localparam logic [7:0]    LIMIT = 8'(POLL_LIMIT);

    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD,
        P_SETUP, P_STROBE, P_HOLD
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    poll_cnt, poll_n;
    logic          bank_q, bank_n;
    logic [7:0]    addr_q, addr_n, data_q, data_n;
    logic          sample, done_n, timeout_n;
    logic          cs_n, wr_n, rd_n, oe_n;
    logic [1:0]    address_n;
    logic [7:0]    dout_n;
    logic          last_cnt;

    assign last_cnt = (cnt == '0);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt - CW'(1);
        poll_n    = poll_cnt;
        bank_n    = bank_q;
        addr_n    = addr_q;
        data_n    = data_q;
        sample    = 1'b0;
        done_n    = 1'b0;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = cnt;
                if (req_valid && req_ready) begin
                    bank_n  = req_bank;
                    addr_n  = req_addr;
                    data_n  = req_data;
                    poll_n  = '0;
                    state_n = A_SETUP;
                    cnt_n   = S_LD;
                end
            end
            A_SETUP:  if (last_cnt) begin state_n = A_STROBE; cnt_n = W_LD; end
            A_STROBE: if (last_cnt) begin state_n = A_HOLD;   cnt_n = H_LD; end
            A_HOLD:   if (last_cnt) begin state_n = D_SETUP;  cnt_n = S_LD; end
            D_SETUP:  if (last_cnt) begin state_n = D_STROBE; cnt_n = W_LD; end
            D_STROBE: if (last_cnt) begin state_n = D_HOLD;   cnt_n = H_LD; end
            D_HOLD: begin
                if (last_cnt) begin
                    if (POLL_EN != 0) begin
                        state_n = P_SETUP;
                        cnt_n   = S_LD;
                    end else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            P_SETUP:  if (last_cnt) begin state_n = P_STROBE; cnt_n = W_LD; end
            P_STROBE: begin
                if (last_cnt) begin
                    sample  = 1'b1;
                    poll_n  = (poll_cnt == LIMIT) ? poll_cnt : poll_cnt + 8'd1;
                    state_n = P_HOLD;
                    cnt_n   = H_LD;
                end
            end
            P_HOLD: begin
                // last_status was captured at the end of P_STROBE, so it is stable here
                if (last_cnt) begin
                    if (!last_status[7] || poll_cnt == LIMIT) begin
                        state_n   = IDLE;
                        done_n    = 1'b1;
                        timeout_n = last_status[7];
                    end else begin
                        state_n = P_SETUP;
                        cnt_n   = S_LD;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output values are decoded from the next state so they register alongside it.
    always_comb begin
        cs_n      = 1'b1;
        wr_n      = 1'b1;
        rd_n      = 1'b1;
        oe_n      = 1'b0;
        address_n = '0;
        dout_n    = '0;
        case (state_n)
            A_SETUP, A_STROBE, A_HOLD: begin
                address_n = {bank_n, 1'b0};
                dout_n    = addr_n;
                oe_n      = 1'b1;
                if (state_n == A_STROBE) begin cs_n = 1'b0; wr_n = 1'b0; end
            end
            D_SETUP, D_STROBE, D_HOLD: begin
                address_n = {bank_n, 1'b1};
                dout_n    = data_n;
                oe_n      = 1'b1;
                if (state_n == D_STROBE) begin cs_n = 1'b0; wr_n = 1'b0; end
            end
            P_STROBE: begin
                cs_n = 1'b0;
                rd_n = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            poll_cnt    <= '0;
            bank_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            req_ready   <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            last_status <= '0;
            CS          <= 1'b1;
            WR          <= 1'b1;
            RD          <= 1'b1;
            ADDRESS     <= '0;
            bus_data_o  <= '0;
            bus_data_oe <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            poll_cnt    <= poll_n;
            bank_q      <= bank_n;
            addr_q      <= addr_n;
            data_q      <= data_n;
            req_ready   <= (state_n == IDLE);
            done        <= done_n;
            timeout     <= timeout_n;
            if (sample) last_status <= bus_data_i;
            CS          <= cs_n;
            WR          <= wr_n;
            RD          <= rd_n;
            ADDRESS     <= address_n;
            bus_data_o  <= dout_n;
            bus_data_oe <= oe_n;
        end
    end

endmodule

// File: doc/ym3438_bus_master.md
Name: ym3438_bus_master

Overview:
- Host-side initiator for the YM3438 CPU bus: takes register-write requests (bank, register address, data) and generates the two-phase write sequence the chip's io block receives.
- Sequence: address write, then data write. Optionally polls the status register until the busy flag (bit 7) clears.
- Used in benches and in FPGA top-levels where a soft CPU or sequencer programs the core.
- Drives CS/WR/RD/ADDRESS/DATA into ym3438 and reads DATA_o back.

Parameters:
- SETUP_CYCLES, 2: MCLK cycles with ADDRESS/data/oe valid before the strobe asserts (≥1).
- STROBE_CYCLES, 4: MCLK cycles CS and WR (or CS and RD) are held low (≥1).
- HOLD_CYCLES, 2: MCLK cycles ADDRESS/data/oe are held after the strobe deasserts (≥1).
- POLL_EN, 1: 1 = poll the busy flag after every data write; 0 = no polling.
- POLL_LIMIT, 255: maximum status reads before abort with timeout (1..255).

Ports:
- MCLK, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- req_valid, input, 1: write request present.
- req_ready, output, 1: block idle and able to accept.
- req_bank, input, 1: register bank; drives A1.
- req_addr, input, 8: register address.
- req_data, input, 8: register data.
- done, output, 1: one-cycle pulse when a request completes.
- timeout, output, 1: qualifies done; busy was still set after POLL_LIMIT reads.
- last_status, output, 8: last sampled status byte.
- CS, output, 1: chip select, active-low.
- WR, output, 1: write strobe, active-low.
- RD, output, 1: read strobe, active-low.
- ADDRESS, output, 2: A1:A0.
- bus_data_o, output, 8: data driven to the chip.
- bus_data_oe, output, 1: 1 = master drives the bus.
- bus_data_i, input, 8: data read from the chip (status).

Behaviour:
- All outputs are registered.
- Reset values: CS=WR=RD=1, ADDRESS=0, bus_data_o=0, bus_data_oe=0, req_ready=0 during reset, done=0, timeout=0, last_status=0. On the first cycle after reset deasserts: IDLE with req_ready=1.
- Reset mid-operation aborts at the next edge: strobes high, oe low, no done pulse.
- States: IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, P_SETUP, P_STROBE, P_HOLD. One down-counter reloads on every state entry.
- IDLE:
  - req_ready=1.
  - On req_valid: latch bank/addr/data, clear the poll counter, go to A_SETUP.
  - req_* are ignored outside IDLE.
- Address phase:
  - A_SETUP: ADDRESS={bank,0}, bus_data_o=addr, oe=1, CS=WR=1.
  - A_STROBE: CS=WR=0.
  - A_HOLD: CS=WR=1, bus values held.
- Data phase: the same three states with ADDRESS={bank,1} and bus_data_o=data.
- After D_HOLD:
  - POLL_EN=0: return to IDLE with done=1.
  - POLL_EN=1: go to P_SETUP.
- Poll phase:
  - P_SETUP: ADDRESS=0, oe=0.
  - P_STROBE: CS=RD=0. bus_data_i is sampled into last_status on the last P_STROBE cycle; the poll counter increments.
  - P_HOLD: CS=RD=1.
  - After P_HOLD:
    - status bit7=0: IDLE, done=1, timeout=0.
    - bit7=1 and poll count == POLL_LIMIT: IDLE, done=1, timeout=1.
    - otherwise: back to P_SETUP.
- WR and RD are never low simultaneously. CS is high in every SETUP and HOLD cycle, so the chip sees distinct edges.
- Latency with the accept cycle as cycle 0:
  - POLL_EN=0: done at cycle 2·(S+W+H)+1. Defaults: 17.
  - POLL_EN=1: done at cycle (2+n)·(S+W+H)+1 for n status reads.
- done and req_ready are both 1 in the completion cycle. A req_valid seen then is accepted, so back-to-back requests have zero idle gap.
- timeout is meaningful only while done=1. It is 0 otherwise.
- Counter width is sized for max(S,W,H). The poll counter is 8 bits and saturates at POLL_LIMIT.

Test Plan:
- Reset released, POLL_EN=0; req bank=0 addr=0x28 data=0xF0 → ADDRESS=00/data 0x28 with CS,WR low in cycles 3–6, then ADDRESS=01/data 0xF0 with CS,WR low in cycles 11–14; done at cycle 17; RD never low.
- bank=1 addr=0xB4 data=0xC0 → ADDRESS=10 then 11; bus_data_oe=1 from cycle 1 to 16, 0 in IDLE.
- POLL_EN=1, bus_data_i returns 0x80,0x80,0x00 → exactly 3 RD strobes at ADDRESS=00; last_status=0x00; done at cycle 41; timeout=0.
- POLL_LIMIT=4, bus_data_i stuck at 0x80 → 4 status reads; done with timeout=1; last_status=0x80.
- reset asserted during D_STROBE → next cycle CS=WR=RD=1, oe=0, no done; after release req_ready=1 and a new request completes normally.
- req_valid held high with two queued requests → the second is accepted in the same cycle as the first done pulse; its A_SETUP starts the following cycle; req_* changes mid-transfer do not alter the bus.
